counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of the command length field; run length is len+1 cycles.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req_valid[i]  input  1  command offered by requester i, i=0,1.
REQ-005 SHALL have ports req_ready[i]  output  1  command from requester i accepted this cycle, i=0,1.
REQ-006 SHALL have ports req_modo[i]  input  2  counter mode: 00 up, 01 down, 10 down-by-3, 11 load, i=0,1.
REQ-007 SHALL have ports req_D[i]  input  4  load value, used only when mode 11, i=0,1.
REQ-008 SHALL have ports req_len[i]  input  LEN_W  run length minus one, i=0,1.
REQ-009 SHALL have port abort  input  1  terminate the running command.
REQ-010 SHALL have port cnt_rco  input  1  carry/wrap flag from the counter.
REQ-011 SHALL have ports cnt_enable (1), cnt_modo (2), cnt_D (4), cnt_reset (1), all outputs, driving the counter's enable, modo, D and active-high synchronous reset.
REQ-012 SHALL have outputs busy (1), grant_id (1), done (1), done_abort (1), done_rco (1) and rco_cnt (8).

Function
REQ-013 FSM states SHALL be INIT, IDLE, RUN, DONE.
REQ-014 INIT: one cycle with cnt_enable=1 and cnt_reset=1, then IDLE.
REQ-015 IDLE: req_ready SHALL be high, combinationally, for at most one requester: the round-robin winner among valid requesters.
REQ-016 Handshake = valid&ready; on it, latch modo/D/len, set grant_id, then go RUN.
REQ-017 RUN: cnt_enable=1 with latched cnt_modo/cnt_D; remaining length decrements each cycle; exit to DONE after the cycle in which remaining==0.
REQ-018 Latency: handshake in cycle N gives cnt_enable high in cycles N+1..N+1+len and a one-cycle done pulse in N+2+len.
REQ-019 DONE: cnt_enable=0, done=1 for one cycle, round-robin pointer moves to the other requester, then IDLE; a new handshake is possible no earlier than the cycle after DONE.
REQ-020 Outside RUN/INIT, cnt_enable=0 and cnt_reset=0; cnt_modo/cnt_D hold their last values.
REQ-021 Arbitration: both valid with pointer=0 grants 0; a single valid requester is granted regardless of pointer.
REQ-022 abort sampled high in any RUN cycle, including the last, ends RUN at that edge and gives DONE with done_abort=1; abort is ignored in INIT/IDLE/DONE.
REQ-023 rco_cnt SHALL increment on every clock with cnt_rco=1 and saturate at 255.
REQ-024 busy SHALL be 1 in INIT, RUN and DONE.
REQ-025 len=0 SHALL give exactly one enable cycle; len=all-ones SHALL give 2^LEN_W enable cycles.
REQ-026 done_abort and done_rco SHALL be valid only while done=1 and 0 otherwise.

Reset
REQ-027 reset low SHALL immediately force state=INIT, pointer=0, grant_id=0, rco_cnt=0, all other outputs 0, including mid-RUN.
REQ-028 INIT SHALL begin on the first clock edge after reset deasserts.

Configuration
REQ-029 With COUNTER_CTRL_RCO_STOP_EN defined, cnt_rco=1 sampled in a RUN cycle SHALL end RUN at that edge, with done_rco=1 in DONE.
REQ-030 With COUNTER_CTRL_RCO_STOP_EN defined, if abort and cnt_rco are both high in the same RUN cycle, done_abort=1 and done_rco=1.
REQ-031 Without COUNTER_CTRL_RCO_STOP_EN, cnt_rco SHALL only feed rco_cnt, and done_rco SHALL be tied 0.

Structure
REQ-032 Package counter_ctrl_pkg SHALL hold the state enum, mode constants MODE_UP/MODE_DOWN/MODE_DOWN3/MODE_LOAD and the command struct {modo, D, len}.
REQ-033 Round-robin selection SHALL be sub-module rr_arb2: inputs valid[1:0] and pointer; output one-hot grant.

Verification
REQ-034 Release reset -> cnt_enable=1 and cnt_reset=1 for one cycle, then busy=0 and req_ready=0 with no requests.
REQ-035 req0 {modo=00, len=3} in cycle N -> cnt_enable high in N+1..N+4 with cnt_modo=00, then done=1 in N+5.
REQ-036 Both valid repeatedly, len=0 -> grants alternate 0,1,0,1 and grant_id matches each grant.
REQ-037 req1 {modo=11, D=9, len=7}, abort in 3rd RUN cycle -> 3 enable cycles with cnt_D=9, then done=1 and done_abort=1.
REQ-038 With COUNTER_CTRL_RCO_STOP_EN, cnt_rco pulsed in 2nd RUN cycle of len=5 -> 2 enable cycles, done_rco=1, rco_cnt=1; without the macro, 6 enable cycles and done_rco=0.
REQ-039 reset low in the middle of RUN -> outputs cleared at once; after release, INIT then IDLE; 300 cnt_rco pulses -> rco_cnt=255.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg -- shared types for the counter controller.
//   state_t  : controller FSM states (INIT, IDLE, RUN, DONE)
//   MODE_*   : counter mode encodings driven on cnt_modo
//   cmd_t    : latched command {modo, D, len}; len is sized for the
//              widest supported LEN_W (16) and zero-extended on capture.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam int unsigned MAX_LEN_W = 16;

  typedef struct packed {
    logic [1:0]           modo;
    logic [3:0]           D;
    logic [MAX_LEN_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/counter_ctrl_rr_arb2.sv
// rr_arb2 -- two-requester round-robin arbiter (purely combinational).
//   valid[1:0] : requests
//   pointer    : requester holding priority this cycle
//   grant[1:0] : one-hot grant (all zero when no request)
// A lone requester always wins regardless of pointer.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~pointer | ~valid[1]);
    grant[1] = valid[1] & ( pointer | ~valid[0]);
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl -- sequences commands from two requesters onto a counter.
//   clk, reset (async, active low)
//   req_valid/req_ready[1:0], req_modo/req_D/req_len[1:0] : command ports
//   abort      : end the running command early
//   cnt_rco    : counter wrap flag, counted into rco_cnt (saturating)
//   cnt_enable/cnt_modo/cnt_D/cnt_reset : counter control
//   busy, grant_id, done, done_abort, done_rco, rco_cnt : status
// Optional feature: COUNTER_CTRL_RCO_STOP_EN -- cnt_rco during RUN also
// terminates the command and is reported on done_rco.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_modo,
  input  logic [1:0][3:0]       req_D,
  input  logic [1:0][LEN_W-1:0] req_len,
  input  logic                  abort,
  input  logic                  cnt_rco,
  output logic                  cnt_enable,
  output logic [1:0]            cnt_modo,
  output logic [3:0]            cnt_D,
  output logic                  cnt_reset,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  done,
  output logic                  done_abort,
  output logic                  done_rco,
  output logic [7:0]            rco_cnt
);

  state_t     state_q, state_d;
  logic       live_q;
  logic       pointer_q;
  cmd_t       cmd_q;
  logic       abort_q;
  logic [1:0] grant;
  logic       hs;
  logic       sel;
  logic       rco_stop;
  logic       run_end;

  rr_arb2 u_arb (
    .valid  (req_valid),
    .pointer(pointer_q),
    .grant  (grant)
  );

  assign sel = grant[1];
  assign hs  = (state_q == IDLE) && (|req_valid);

`ifdef COUNTER_CTRL_RCO_STOP_EN
  logic rco_q;
  assign rco_stop = cnt_rco;
`else
  assign rco_stop = 1'b0;
`endif

  assign run_end = abort || rco_stop || (cmd_q.len == '0);

  // live_q marks the first edge after reset release: INIT is held until
  // then and all INIT-driven outputs stay low while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      live_q    <= 1'b0;
      pointer_q <= 1'b0;
      grant_id  <= 1'b0;
      cmd_q     <= '0;
      abort_q   <= 1'b0;
      rco_cnt   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (cnt_rco && (rco_cnt != 8'hFF)) rco_cnt <= rco_cnt + 8'd1;
      case (state_q)
        IDLE: begin
          if (hs) begin
            grant_id   <= sel;
            cmd_q.modo <= req_modo[sel];
            cmd_q.D    <= req_D[sel];
            cmd_q.len  <= MAX_LEN_W'(req_len[sel]);
          end
        end
        RUN: begin
          abort_q <= abort;
          if (!run_end) cmd_q.len <= cmd_q.len - 1'b1;
        end
        DONE:    pointer_q <= ~grant_id;
        default: ;
      endcase
    end
  end

`ifdef COUNTER_CTRL_RCO_STOP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               rco_q <= 1'b0;
    else if (state_q == RUN)  rco_q <= cnt_rco;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (live_q) state_d = IDLE;
      IDLE:    if (hs) state_d = RUN;
      RUN:     if (run_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    cnt_enable = live_q && ((state_q == INIT) || (state_q == RUN));
    cnt_reset  = live_q && (state_q == INIT);
    busy       = live_q && (state_q != IDLE);
    done       = (state_q == DONE);
    req_ready  = (state_q == IDLE) ? grant : '0;
    cnt_modo   = cmd_q.modo;
    cnt_D      = cmd_q.D;
    done_abort = done && abort_q;
`ifdef COUNTER_CTRL_RCO_STOP_EN
    done_rco   = done && rco_q;
`else
    done_rco   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl -- scoreboard bench for counter_ctrl.
module tb_counter_ctrl;

  localparam int unsigned LEN_W = 4;
`ifdef COUNTER_CTRL_RCO_STOP_EN
  localparam bit RCO_STOP = 1'b1;
`else
  localparam bit RCO_STOP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][1:0]       req_modo = '0;
  logic [1:0][3:0]       req_D = '0;
  logic [1:0][LEN_W-1:0] req_len = '0;
  logic                  abort = 1'b0;
  logic                  cnt_rco = 1'b0;
  logic                  cnt_enable, cnt_reset, busy, grant_id, done, done_abort, done_rco;
  logic [1:0]            cnt_modo;
  logic [3:0]            cnt_D;
  logic [7:0]            rco_cnt;

  counter_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_modo(req_modo), .req_D(req_D), .req_len(req_len),
    .abort(abort), .cnt_rco(cnt_rco),
    .cnt_enable(cnt_enable), .cnt_modo(cnt_modo), .cnt_D(cnt_D), .cnt_reset(cnt_reset),
    .busy(busy), .grant_id(grant_id), .done(done),
    .done_abort(done_abort), .done_rco(done_rco), .rco_cnt(rco_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gid;
    int unsigned en;
    logic [1:0]  modo;
    logic        chk_d;
    logic [3:0]  d;
    logic        dab;
    logic        drc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned done_seen = 0;
  int unsigned cyc = 0, en_cnt = 0, hs_cyc = 0;
  logic [1:0]  last_modo = '0;
  logic [3:0]  last_d = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks enable cycles per command, scores each done pulse.
  always @(negedge clk) begin
    cyc++;
    if (req_valid == 2'b11) chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
    if (|(req_valid & req_ready)) begin
      en_cnt = 0;
      hs_cyc = cyc;
    end
    if (cnt_enable) begin
      en_cnt++;
      last_modo = cnt_modo;
      last_d    = cnt_D;
    end
    if (!done) chk("flags_outside_done", int'(done_abort | done_rco), 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("grant_id", int'(grant_id), int'(e.gid));
        chk("enable_cycles", int'(en_cnt), int'(e.en));
        chk("done_latency", int'(cyc - hs_cyc), int'(e.en + 1));
        chk("cnt_modo", int'(last_modo), int'(e.modo));
        if (e.chk_d) chk("cnt_D", int'(last_d), int'(e.d));
        chk("done_abort", int'(done_abort), int'(e.dab));
        chk("done_rco", int'(done_rco), int'(e.drc));
      end
      done_seen++;
    end
  end

  task automatic push(input logic gid, input int unsigned en, input logic [1:0] modo,
                      input logic chk_d, input logic [3:0] d, input logic dab, input logic drc);
    exp_t x;
    x.gid = gid; x.en = en; x.modo = modo; x.chk_d = chk_d; x.d = d; x.dab = dab; x.drc = drc;
    sb.push_back(x);
  endtask

  // Offers a command and returns #1 after the handshake edge (first RUN cycle).
  task automatic issue(input int i, input logic [1:0] m, input logic [3:0] d, input logic [LEN_W-1:0] len);
    bit ok = 0;
    req_modo[i] = m; req_D[i] = d; req_len[i] = len; req_valid[i] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; break; end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", int'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned target;

    // Reset held: everything low.
    #12;
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_cnt_reset", int'(cnt_reset), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rco_cnt", int'(rco_cnt), 0);
    reset = 1'b1;
    next_cycle();
    chk("init_enable", int'(cnt_enable), 1);
    chk("init_cnt_reset", int'(cnt_reset), 1);
    chk("init_busy", int'(busy), 1);
    next_cycle();
    chk("idle_enable", int'(cnt_enable), 0);
    chk("idle_cnt_reset", int'(cnt_reset), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(req_ready), 0);

    // abort in IDLE must be ignored.
    abort = 1'b1; next_cycle(); next_cycle(); abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);

    // Both valid, len 0: grants alternate 0,1,0,1.
    req_modo[0] = 2'b01; req_D[0] = 4'd3; req_len[0] = '0;
    req_modo[1] = 2'b10; req_D[1] = 4'd4; req_len[1] = '0;
    push(0, 1, 2'b01, 1, 4'd3, 0, 0);
    push(1, 1, 2'b10, 1, 4'd4, 0, 0);
    push(0, 1, 2'b01, 1, 4'd3, 0, 0);
    push(1, 1, 2'b10, 1, 4'd4, 0, 0);
    target = done_seen + 4;
    req_valid = 2'b11;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (done_seen >= target) break;
    end
    #1 req_valid = '0;
    chk("alternate_count", int'(done_seen >= target), 1);
    wait_drain();

    // req0 up, len 3: four enable cycles, done at N+5.
    push(0, 4, 2'b00, 0, 4'd0, 0, 0);
    issue(0, 2'b00, 4'd5, 4'd3);
    wait_drain();

    // req1 load D=9 len 7, abort in third RUN cycle.
    push(1, 3, 2'b11, 1, 4'd9, 1, 0);
    issue(1, 2'b11, 4'd9, 4'd7);
    next_cycle(); next_cycle();
    abort = 1'b1; next_cycle(); abort = 1'b0;
    wait_drain();

    // req1 alone with pointer 0, cnt_rco in second RUN cycle of len 5.
    push(1, RCO_STOP ? 2 : 6, 2'b00, 0, 4'd0, 0, RCO_STOP);
    issue(1, 2'b00, 4'd0, 4'd5);
    next_cycle();
    cnt_rco = 1'b1; next_cycle(); cnt_rco = 1'b0;
    wait_drain();
    chk("rco_cnt_one", int'(rco_cnt), 1);

    // abort in the last RUN cycle of len 1.
    push(0, 2, 2'b01, 0, 4'd0, 1, 0);
    issue(0, 2'b01, 4'd0, 4'd1);
    next_cycle();
    abort = 1'b1; next_cycle(); abort = 1'b0;
    wait_drain();

    // len all-ones: 16 enable cycles (req0 alone while pointer is 1).
    push(0, 16, 2'b10, 0, 4'd0, 0, 0);
    issue(0, 2'b10, 4'd0, 4'hF);
    wait_drain();

    // Load, len 0: one enable cycle.
    push(1, 1, 2'b11, 1, 4'hF, 0, 0);
    issue(1, 2'b11, 4'hF, 4'd0);
    wait_drain();

    // Reset in the middle of RUN.
    issue(1, 2'b11, 4'd6, 4'hF);
    next_cycle(); next_cycle();
    reset = 1'b0;
    #1;
    sb.delete();
    chk("midrst_enable", int'(cnt_enable), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_grant_id", int'(grant_id), 0);
    chk("midrst_rco_cnt", int'(rco_cnt), 0);
    chk("midrst_cnt_D", int'(cnt_D), 0);
    #3 reset = 1'b1;
    next_cycle();
    chk("reinit_enable", int'(cnt_enable), 1);
    chk("reinit_cnt_reset", int'(cnt_reset), 1);
    next_cycle();
    chk("reidle_busy", int'(busy), 0);
    chk("reidle_enable", int'(cnt_enable), 0);

    // rco_cnt saturation.
    cnt_rco = 1'b1;
    repeat (100) @(posedge clk);
    #1 chk("rco_cnt_100", int'(rco_cnt), 100);
    repeat (200) @(posedge clk);
    #1 cnt_rco = 1'b0;
    chk("rco_cnt_sat", int'(rco_cnt), 255);

    chk("sb_empty", int'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
